// File: rtl/i2c_slave_address_ctrl.sv
// Own-address table for the I2C slave: newest-first shift table with add/clear
// configuration and a one-entry-per-cycle match scan toward the receive path.
module i2c_slave_address_ctrl #(
  parameter int LENGTH      = 7,
  parameter int MAX_ADDRESS = 4,
  localparam int IW = (MAX_ADDRESS > 1) ? $clog2(MAX_ADDRESS) : 1,
  localparam int CW = $clog2(MAX_ADDRESS + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CfgValid,
  input  logic              CfgClear,
  input  logic [LENGTH-1:0] CfgAddress,
  output logic              CfgReady,
  input  logic              MatchValid,
  input  logic [LENGTH-1:0] MatchAddress,
  output logic              MatchReady,
  output logic              RespValid,
  output logic              RespHit,
  output logic [IW-1:0]     RespIndex,
  output logic [CW-1:0]     Count,
  output logic [1:0]        DbgState
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LENGTH-1:0] slot_q [MAX_ADDRESS];
  logic [LENGTH-1:0] slot_d [MAX_ADDRESS];
  logic [LENGTH-1:0] addr_q, addr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [IW-1:0]     index_q, index_d;

  // Handshakes: a request transfers on the rising edge where valid && ready;
  // requesters hold valid and payload stable until then. Match wins a tie.
  assign MatchReady = (state_q == S_IDLE);
  assign CfgReady   = (state_q == S_IDLE) && !MatchValid;
  assign RespValid  = (state_q == S_RESP);
  assign RespHit    = hit_q;
  assign RespIndex  = index_q;
  assign Count      = count_q;
  assign DbgState   = state_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    index_d = index_q;
    case (state_q)
      S_IDLE: begin
        if (MatchValid) begin
          addr_d = MatchAddress;
          idx_d  = '0;
          if (count_q == '0) begin
            hit_d   = 1'b0;
            index_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_SEARCH;
          end
        end else if (CfgValid) begin
          if (CfgClear) begin
            count_d = '0;
            for (int i = 0; i < MAX_ADDRESS; i++) slot_d[i] = '0;
          end else begin
            // Oldest entry falls off the end when the table is full.
            for (int i = 1; i < MAX_ADDRESS; i++) slot_d[i] = slot_q[i-1];
            slot_d[0] = CfgAddress;
            if (count_q != CW'(MAX_ADDRESS)) count_d = count_q + CW'(1);
          end
        end
      end
      S_SEARCH: begin
        if (slot_q[idx_q] == addr_q) begin
          hit_d   = 1'b1;
          index_d = idx_q;
          state_d = S_RESP;
        end else if (CW'(idx_q) == count_q - CW'(1)) begin
          hit_d   = 1'b0;
          index_d = '0;
          state_d = S_RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      for (int i = 0; i < MAX_ADDRESS; i++) slot_q[i] <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      index_q <= index_d;
    end
  end

endmodule
